// File: rtl/params.sv
// Request/response bundles shared between the tile address generator and the memory responder.
package params;

  typedef struct packed {
    logic [31:0] BASE;
    logic [1:0]  sel;
    logic        issend;
    logic [5:0]  burst_num;
    logic [2:0]  burst_size;
    logic        request_valid;
  } AXI_out_t;

  typedef struct packed {
    logic         finish;
    logic [255:0] data;
    logic [31:0]  burst_id;
    logic         rvalid;
    logic         arready;
  } AXI_in_t;

endpackage

// File: rtl/tc_mem_responder.sv
// Memory-side responder: accepts one request at a time and streams 256-bit beats out of a
// preloadable word-addressed memory, ending each request with a finish pulse.
module tc_mem_responder
  import params::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  AXI_out_t                 req_i,
  output AXI_in_t                  rsp_o,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0]    ld_data
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_lat, w_lat_nxt;
  logic [AW-1:0]         r_ptr;
  logic [5:0]            r_num;
  logic [5:0]            r_idx, w_idx_nxt;
  logic                  r_send;
  logic                  r_arready, w_arready_nxt;
  logic                  r_rvalid, w_rvalid_nxt;
  logic                  r_finish, w_finish_nxt;
  logic                  w_hs;
  logic                  w_beat;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_unused;

  assign w_unused = ^{req_i.BASE[31:5+AW], req_i.BASE[4:0], req_i.sel, req_i.burst_size};

  // BURST stays resident while the last beat is on the bus; the exit to IDLE
  // happens on the following edge so every output remains a plain register.
  always_comb begin
    w_state_nxt   = r_state;
    w_lat_nxt     = r_lat;
    w_idx_nxt     = r_idx;
    w_arready_nxt = 1'b0;
    w_rvalid_nxt  = 1'b0;
    w_finish_nxt  = 1'b0;
    w_hs          = 1'b0;
    w_beat        = 1'b0;
    case (r_state)
      IDLE: begin
        w_arready_nxt = 1'b1;
        if (r_arready && req_i.request_valid) begin
          w_hs          = 1'b1;
          w_arready_nxt = 1'b0;
          w_lat_nxt     = 4'(LATENCY - 1);
          w_state_nxt   = WAIT;
        end
      end
      WAIT: begin
        if (r_lat == '0) begin
          if (!r_send && (r_num != '0)) begin
            w_state_nxt  = BURST;
            w_beat       = 1'b1;
            w_idx_nxt    = '0;
            w_rvalid_nxt = 1'b1;
            w_finish_nxt = (r_num == 6'd1);
          end else begin
            w_state_nxt  = DONE;
            w_finish_nxt = 1'b1;
          end
        end else begin
          w_lat_nxt = r_lat - 4'd1;
        end
      end
      BURST: begin
        if (r_finish) begin
          w_state_nxt   = IDLE;
          w_arready_nxt = 1'b1;
        end else begin
          w_beat       = 1'b1;
          w_idx_nxt    = r_idx + 6'd1;
          w_rvalid_nxt = 1'b1;
          w_finish_nxt = (w_idx_nxt == (r_num - 6'd1));
        end
      end
      DONE: begin
        w_state_nxt   = IDLE;
        w_arready_nxt = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lat     <= '0;
      r_ptr     <= '0;
      r_num     <= '0;
      r_idx     <= '0;
      r_send    <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_finish  <= 1'b0;
      r_data    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_lat     <= w_lat_nxt;
      r_idx     <= w_idx_nxt;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      r_finish  <= w_finish_nxt;
      if (w_hs) begin
        r_ptr  <= req_i.BASE[5 +: AW];
        r_num  <= req_i.burst_num;
        r_send <= req_i.issend;
      end else if (w_beat) begin
        r_ptr <= r_ptr + 1'b1;
      end
      if (w_beat) begin
        r_data <= r_mem[r_ptr];
      end
    end
  end

  // Non-blocking write means a same-edge beat read still sees the old word.
  always_ff @(posedge clk) begin
    if (ld_en) begin
      r_mem[ld_addr] <= ld_data;
    end
  end

  assign rsp_o = '{
    finish:   r_finish,
    data:     r_data,
    burst_id: {26'd0, r_idx},
    rvalid:   r_rvalid,
    arready:  r_arready
  };

endmodule

// File: tb/tb_tc_mem_responder.sv
// Scoreboard bench for tc_mem_responder: requests push expected beats, a negedge monitor checks them.
module tb_tc_mem_responder;
  import params::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 1024;

  typedef struct {
    int           t;
    logic         rv;
    logic         fin;
    logic [255:0] d;
    logic [31:0]  bid;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  AXI_out_t     req;
  AXI_in_t      rsp;
  logic         ld_en;
  logic [9:0]   ld_addr;
  logic [255:0] ld_data;

  int           cyc = 0;
  int           n_chk = 0;
  int           n_err = 0;
  exp_t         q[$];
  exp_t         e;
  logic [255:0] model [DEPTH];

  tc_mem_responder #(.DATA_WIDTH(256), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .rsp_o  (rsp),
    .ld_en  (ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endfunction

  function automatic logic [255:0] pat(input logic [31:0] v);
    return {~v, 192'd0, v};
  endfunction

  // Monitor: every presented response must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && (rsp.rvalid || rsp.finish)) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_rsp @cyc %0d: got rvalid=%0b finish=%0b id=%0d expected no response",
                 cyc, rsp.rvalid, rsp.finish, rsp.burst_id);
      end else begin
        e = q.pop_front();
        chk("rsp_time", 256'(cyc), 256'(e.t));
        chk("rvalid", 256'(rsp.rvalid), 256'(e.rv));
        chk("finish", 256'(rsp.finish), 256'(e.fin));
        if (e.rv) begin
          chk("data", rsp.data, e.d);
          chk("burst_id", 256'(rsp.burst_id), 256'(e.bid));
        end
      end
    end
  end

  task automatic preload(input int a, input logic [255:0] d);
    ld_en   = 1'b1;
    ld_addr = 10'(a);
    ld_data = d;
    model[a] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_req(input logic [31:0] base, input logic [5:0] num, input logic send,
                        input bit hold, output int hs);
    int   k;
    int   w;
    exp_t x;
    req.BASE          = base;
    req.burst_num     = num;
    req.issend        = send;
    req.sel           = 2'($urandom_range(3));
    req.burst_size    = 3'($urandom_range(7));
    req.request_valid = 1'b1;
    k = 0;
    while (!rsp.arready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!rsp.arready) begin
      n_chk++;
      n_err++;
      $display("FAIL handshake_timeout: got arready=0 expected arready=1 within 100 cycles");
      req.request_valid = 1'b0;
      hs = -1;
      return;
    end
    hs = cyc + 1;
    w  = int'(base[14:5]);
    if (send || num == 6'd0) begin
      x.t = hs + LAT; x.rv = 1'b0; x.fin = 1'b1; x.d = '0; x.bid = '0;
      q.push_back(x);
    end else begin
      for (int i = 0; i < int'(num); i++) begin
        x.t   = hs + LAT + i;
        x.rv  = 1'b1;
        x.fin = (i == int'(num) - 1);
        x.d   = model[(w + i) % DEPTH];
        x.bid = 32'(i);
        q.push_back(x);
      end
    end
    @(negedge clk);
    if (!hold) req.request_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1);
  end

  initial begin
    int hs, hs2;
    req     = '0;
    ld_en   = 1'b0;
    ld_addr = '0;
    ld_data = '0;

    #1;
    chk("rst_rvalid", 256'(rsp.rvalid), 256'd0);
    chk("rst_finish", 256'(rsp.finish), 256'd0);
    chk("rst_arready", 256'(rsp.arready), 256'd0);
    chk("rst_data", rsp.data, 256'd0);
    chk("rst_burst_id", 256'(rsp.burst_id), 256'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("arready_before_edge", 256'(rsp.arready), 256'd0);
    @(negedge clk);
    chk("arready_after_edge", 256'(rsp.arready), 256'd1);

    for (int i = 0; i < 8; i++) preload(i, pat(32'hA0 + 32'(i)));
    preload(1022, pat(32'hB1022));
    preload(1023, pat(32'hB1023));

    // Basic 4-beat read, arready returns the cycle after finish.
    do_req(32'h0, 6'd4, 1'b0, 1'b0, hs);
    wait_to(hs + LAT + 3);
    chk("arready_at_finish", 256'(rsp.arready), 256'd0);
    wait_to(hs + LAT + 4);
    chk("arready_after_finish", 256'(rsp.arready), 256'd1);

    do_req(32'h40, 6'd1, 1'b0, 1'b0, hs);
    do_req(32'(1022 * 32), 6'd4, 1'b0, 1'b0, hs);
    do_req(32'h0, 6'd8, 1'b1, 1'b0, hs);
    do_req(32'h60, 6'd0, 1'b0, 1'b0, hs);

    // Held request: one extra handshake exactly LAT+N+1 later.
    do_req(32'h20, 6'd4, 1'b0, 1'b1, hs);
    do_req(32'h20, 6'd4, 1'b0, 1'b1, hs2);
    req.request_valid = 1'b0;
    chk("busy_spacing", 256'(hs2 - hs), 256'(LAT + 4 + 1));

    // Preload of mem[1] on the same edge beat 1 reads it.
    do_req(32'h0, 6'd3, 1'b0, 1'b0, hs);
    wait_to(hs + LAT);
    ld_en   = 1'b1;
    ld_addr = 10'd1;
    ld_data = pat(32'hFF);
    @(negedge clk);
    ld_en    = 1'b0;
    model[1] = pat(32'hFF);
    do_req(32'h20, 6'd1, 1'b0, 1'b0, hs);

    // Reset during beat 2 of 6.
    do_req(32'h0, 6'd6, 1'b0, 1'b0, hs);
    wait_to(hs + LAT + 2);
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_rvalid", 256'(rsp.rvalid), 256'd0);
    chk("midrst_finish", 256'(rsp.finish), 256'd0);
    chk("midrst_arready", 256'(rsp.arready), 256'd0);
    chk("midrst_data", rsp.data, 256'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("postrst_arready_low", 256'(rsp.arready), 256'd0);
    @(negedge clk);
    chk("postrst_arready_high", 256'(rsp.arready), 256'd1);
    do_req(32'h0, 6'd4, 1'b0, 1'b0, hs);
    do_req(32'(1022 * 32), 6'd2, 1'b0, 1'b0, hs);

    wait_to(cyc + 12);
    chk("queue_drained", 256'(q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/tc_mem_responder.md
# tc_mem_responder

Memory-side responder for the tensor-core load/store request channel (`AXI_out_t` / `AXI_in_t` in `params`). It accepts one request at a time from the tile's address generator and returns a 256-bit data stream out of an internal word-addressed memory. Each returned beat is tagged with its index. A `finish` pulse marks the end of each request. The block serves as the A/B/C operand source in block-level simulation, and the host fills its memory through a preload port.

## Interface
Parameters:
- `DATA_WIDTH`, 256: beat width in bits. Fixed to match `AXI_in_t.data`.
- `DEPTH`, 1024: number of memory words, each `DATA_WIDTH` bits. Must be a power of two.
- `LATENCY`, 2: cycles from request acceptance to the first beat. Valid range is 1..15.

Ports:
- `clk` in 1: the only clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req_i` in `$bits(AXI_out_t)`: request bundle with fields `BASE`, `sel`, `issend`, `burst_num`, `burst_size`, `request_valid`.
- `rsp_o` out `$bits(AXI_in_t)`: response bundle with fields `finish`, `data`, `burst_id`, `rvalid`, `arready`.
- `ld_en` in 1: preload write enable.
- `ld_addr` in `$clog2(DEPTH)`: preload word address.
- `ld_data` in `DATA_WIDTH`: preload data.

## Operation
- States: IDLE, WAIT, BURST, DONE.
- IDLE
  - `arready`=1.
  - Handshake occurs when `request_valid && arready` at a rising edge.
  - On handshake, latch the fields below, load the latency counter with `LATENCY-1`, and go to WAIT.
  - Latched word pointer = `BASE[31:5]` mod `DEPTH`.
  - Latched beat count = `burst_num`.
  - Latched flag = `issend`.
  - `sel` and `burst_size` are ignored. Every beat always advances the pointer by one 32-byte word.
- WAIT
  - `arready`=0; the counter decrements each cycle.
  - When the counter reaches 0 and the request is a read with `burst_num`≠0, go to BURST.
  - When the counter reaches 0 otherwise, go to DONE.
- BURST
  - Drives one beat per cycle with no gaps and no back-pressure, since the interface has no ready signal.
  - Beat i: `rvalid`=1, `data`=mem[(ptr+i) mod `DEPTH`], `burst_id`=i zero-extended to 32 bits.
  - On the last beat (i=`burst_num`-1), also drive `finish`=1 and go to IDLE.
- DONE
  - Used for `issend`=1 requests and for zero-length reads. Write data travels on a separate path, so this block only acknowledges.
  - Drives `finish`=1 with `rvalid`=0 for one cycle, then goes to IDLE.
- Address wrap: the pointer wraps modulo `DEPTH`, so a burst that crosses the top of memory continues at word 0.
- Preload
  - `ld_en` writes mem[`ld_addr`] at the edge and takes effect from the next cycle.
  - Preload is allowed in any state.
  - If a preload and a beat read target the same word in the same cycle, the beat returns the old data.
- Memory contents are not reset.

## Timing
- Reset values, applied asynchronously while `rst_n`=0:
  - `arready`=0, `rvalid`=0, `finish`=0, `data`=0, `burst_id`=0.
  - FSM in IDLE.
- `arready` rises at the first rising edge after `rst_n` deasserts.
- Reset asserted mid-burst aborts the request. No `finish` is emitted for it.
- All outputs are registered.
- Handshake at edge E0:
  - `arready` is 0 from the cycle after E0.
  - The first beat (or the DONE `finish`) is visible after edge E0+`LATENCY`.
- Read of N beats (N≥1):
  - Beats occupy N consecutive cycles.
  - `finish` coincides with the last beat.
  - `arready` returns to 1 in the cycle after `finish`.
  - Minimum request-to-request spacing is therefore `LATENCY`+N+1 cycles.
- `request_valid` while `arready`=0 is ignored and not queued. The requester must hold the request until the handshake.
- `burst_num`=63 is the maximum. `burst_id` never exceeds 62.

## Test plan
- Basic read:
  - Preload mem[0..3]=0xA0..0xA3, then request `BASE`=0, `burst_num`=4, `LATENCY`=2.
  - `rvalid` is high for 4 consecutive cycles beginning 2 edges after the handshake.
  - `data` = A0, A1, A2, A3 and `burst_id` = 0..3.
  - `finish` is high with `burst_id`=3; `arready` is high the next cycle.
- Byte-address mapping:
  - Request `BASE`=0x40, `burst_num`=1.
  - Returns mem[2] with `finish` and `rvalid` in the same cycle.
- Wrap-around:
  - `DEPTH`=1024, `BASE`=1022×32, `burst_num`=4.
  - `data` = mem[1022], mem[1023], mem[0], mem[1].
- Write and zero-length acknowledge:
  - Request with `issend`=1, `burst_num`=8: a single `finish` pulse 2 edges after the handshake, with `rvalid` never high.
  - Read with `burst_num`=0 gives the same response.
- Busy and ignored requests:
  - Hold `request_valid` high through an entire 4-beat burst.
  - Exactly one further handshake occurs, in the cycle after `finish`. No extra beats appear.
- Reset mid-burst:
  - Assert `rst_n`=0 during beat 2 of 6.
  - `rvalid`, `finish` and `arready` drop to 0 immediately.
  - After release, `arready`=1 one edge later and memory still holds the preloaded values.
- Preload collision:
  - Write mem[1]=0xFF in the cycle that beat 1 reads mem[1].
  - Beat 1 returns the old value; a following request for mem[1] returns 0xFF.
